tlb_cmd_sequencer: RTL and testbench

Sits in front of one TLB instance and sequences all access to its single command port. Two sources share the port: pipeline lookups and a software maintenance command channel. Maintenance commands are insert, invalidate page, invalidate range and invalidate all. The block arbitrates between the sources, guarantees the TLB never sees more than one of lookup_en/update_en/invalidate_en/invalidate_all_en in a cycle, and expands range invalidates into per-page invalidates.

---
 rtl/tlb_cmd_sequencer_pkg.sv | 33 +++
 rtl/tlb_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_tlb_cmd_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_cmd_sequencer_pkg.sv
// Shared TLB definitions: page/ASID widths and the maintenance command encoding
// used by the command sequencer.
package tlb_cmd_sequencer_pkg;

    localparam int PAGE_NUM_BITS = 20;
    localparam int ASID_WIDTH    = 16;

    typedef logic [PAGE_NUM_BITS-1:0] page_index_t;

    typedef enum logic [1:0] {
        INSERT      = 2'd0,
        INVAL_PAGE  = 2'd1,
        INVAL_RANGE = 2'd2,
        INVAL_ALL   = 2'd3
    } tlb_cmd_t;

    // Latched copy of a maintenance command while it waits for / occupies the port.
    typedef struct packed {
        tlb_cmd_t              op;
        page_index_t           vpage;
        logic [ASID_WIDTH-1:0] asid;
        page_index_t           ppage;
        logic                  present;
        logic                  exe_writable;
        logic                  supervisor;
        logic                  glb;
    } cmd_latch_t;

    function automatic logic is_range_op(input tlb_cmd_t op);
        return op == INVAL_RANGE;
    endfunction

endpackage

// File: rtl/tlb_cmd_sequencer.sv
// Arbitrates the single TLB command port between pipeline lookups and software
// maintenance commands, expanding range invalidates into per-page invalidates.
module tlb_cmd_sequencer
    import tlb_cmd_sequencer_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   lookup_req,
    input  page_index_t            lookup_vpage,
    input  logic [ASID_WIDTH-1:0]  lookup_asid,
    output logic                   lookup_grant,
    output logic                   lookup_resp_valid,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  tlb_cmd_t               cmd_op,
    input  page_index_t            cmd_vpage,
    input  logic [ASID_WIDTH-1:0]  cmd_asid,
    input  page_index_t            cmd_ppage,
    input  logic                   cmd_present,
    input  logic                   cmd_exe_writable,
    input  logic                   cmd_supervisor,
    input  logic                   cmd_global,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   cmd_done,

    output logic                   tlb_lookup_en,
    output logic                   tlb_update_en,
    output logic                   tlb_invalidate_en,
    output logic                   tlb_invalidate_all_en,
    output page_index_t            tlb_request_vpage_idx,
    output logic [ASID_WIDTH-1:0]  tlb_request_asid,
    output page_index_t            tlb_update_ppage_idx,
    output logic                   tlb_update_present,
    output logic                   tlb_update_exe_writable,
    output logic                   tlb_update_supervisor,
    output logic                   tlb_update_global,

    output logic [1:0]             fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // STARVE_LIMIT is bounded to 1..15, so a 4-bit counter always suffices.
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] LAST_PAGE = COUNT_WIDTH'(1);

    logic [1:0]             state;
    logic [3:0]             starve_cnt;
    cmd_latch_t             cmd_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   cmd_active;
    logic                   cmd_issue;

    assign cmd_active   = (state == S_PEND) || (state == S_SWEEP);
    assign cmd_issue    = cmd_active && (!lookup_req || (starve_cnt == STARVE_MAX));
    assign lookup_grant = lookup_req && !cmd_issue;

    assign cmd_ready = (state == S_IDLE);
    assign cmd_done  = (state == S_DONE);
    assign fsm_state = state;

    assign tlb_lookup_en         = lookup_grant;
    assign tlb_update_en         = cmd_issue && (cmd_q.op == INSERT);
    assign tlb_invalidate_en     = cmd_issue && ((cmd_q.op == INVAL_PAGE) || (cmd_q.op == INVAL_RANGE));
    assign tlb_invalidate_all_en = cmd_issue && (cmd_q.op == INVAL_ALL);

    assign tlb_update_ppage_idx    = cmd_q.ppage;
    assign tlb_update_present      = cmd_q.present;
    assign tlb_update_exe_writable = cmd_q.exe_writable;
    assign tlb_update_supervisor   = cmd_q.supervisor;
    assign tlb_update_global       = cmd_q.glb;

    // Request fields follow whichever source owns the port; zero when idle.
    always_comb begin
        tlb_request_vpage_idx = '0;
        tlb_request_asid      = '0;
        if (cmd_issue) begin
            tlb_request_vpage_idx = cmd_q.vpage;
            tlb_request_asid      = cmd_q.asid;
        end else if (lookup_grant) begin
            tlb_request_vpage_idx = lookup_vpage;
            tlb_request_asid      = lookup_asid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookup_resp_valid <= 1'b0;
        end else begin
            lookup_resp_valid <= lookup_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            cmd_q      <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    starve_cnt <= '0;
                    if (cmd_valid) begin
                        cmd_q.op           <= cmd_op;
                        cmd_q.vpage        <= cmd_vpage;
                        cmd_q.asid         <= cmd_asid;
                        cmd_q.ppage        <= cmd_ppage;
                        cmd_q.present      <= cmd_present;
                        cmd_q.exe_writable <= cmd_exe_writable;
                        cmd_q.supervisor   <= cmd_supervisor;
                        cmd_q.glb          <= cmd_global;
                        remaining          <= cmd_count;
                        if (is_range_op(cmd_op) && (cmd_count == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_PEND;
                        end
                    end
                end
                S_PEND, S_SWEEP: begin
                    if (cmd_issue) begin
                        starve_cnt <= '0;
                        if (is_range_op(cmd_q.op)) begin
                            // Page index wraps naturally at the page-number width.
                            cmd_q.vpage <= cmd_q.vpage + 1'b1;
                            remaining   <= remaining - 1'b1;
                            state       <= (remaining == LAST_PAGE) ? S_DONE : S_SWEEP;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                default: begin
                    starve_cnt <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_cmd_sequencer.sv
// Directed and randomized-lookup bench for tlb_cmd_sequencer: latency, range
// expansion with wrap, starvation forcing, zero-count ranges and mid-sweep reset.
module tb_tlb_cmd_sequencer;
    import tlb_cmd_sequencer_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int COUNT_WIDTH  = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   lookup_req;
    page_index_t            lookup_vpage;
    logic [ASID_WIDTH-1:0]  lookup_asid;
    logic                   lookup_grant;
    logic                   lookup_resp_valid;
    logic                   cmd_valid;
    logic                   cmd_ready;
    tlb_cmd_t               cmd_op;
    page_index_t            cmd_vpage;
    logic [ASID_WIDTH-1:0]  cmd_asid;
    page_index_t            cmd_ppage;
    logic                   cmd_present;
    logic                   cmd_exe_writable;
    logic                   cmd_supervisor;
    logic                   cmd_global;
    logic [COUNT_WIDTH-1:0] cmd_count;
    logic                   cmd_done;
    logic                   tlb_lookup_en;
    logic                   tlb_update_en;
    logic                   tlb_invalidate_en;
    logic                   tlb_invalidate_all_en;
    page_index_t            tlb_request_vpage_idx;
    logic [ASID_WIDTH-1:0]  tlb_request_asid;
    page_index_t            tlb_update_ppage_idx;
    logic                   tlb_update_present;
    logic                   tlb_update_exe_writable;
    logic                   tlb_update_supervisor;
    logic                   tlb_update_global;
    logic [1:0]             fsm_state;

    logic [3:0] strobes;
    assign strobes = {tlb_lookup_en, tlb_update_en, tlb_invalidate_en, tlb_invalidate_all_en};

    int checks = 0;
    int errors = 0;

    tlb_cmd_sequencer #(.STARVE_LIMIT(STARVE_LIMIT), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .lookup_req(lookup_req), .lookup_vpage(lookup_vpage), .lookup_asid(lookup_asid),
        .lookup_grant(lookup_grant), .lookup_resp_valid(lookup_resp_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_vpage(cmd_vpage), .cmd_asid(cmd_asid), .cmd_ppage(cmd_ppage),
        .cmd_present(cmd_present), .cmd_exe_writable(cmd_exe_writable),
        .cmd_supervisor(cmd_supervisor), .cmd_global(cmd_global),
        .cmd_count(cmd_count), .cmd_done(cmd_done),
        .tlb_lookup_en(tlb_lookup_en), .tlb_update_en(tlb_update_en),
        .tlb_invalidate_en(tlb_invalidate_en), .tlb_invalidate_all_en(tlb_invalidate_all_en),
        .tlb_request_vpage_idx(tlb_request_vpage_idx), .tlb_request_asid(tlb_request_asid),
        .tlb_update_ppage_idx(tlb_update_ppage_idx), .tlb_update_present(tlb_update_present),
        .tlb_update_exe_writable(tlb_update_exe_writable),
        .tlb_update_supervisor(tlb_update_supervisor), .tlb_update_global(tlb_update_global),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_cmd();
        cmd_valid        = 1'b0;
        cmd_op           = INSERT;
        cmd_vpage        = '0;
        cmd_asid         = '0;
        cmd_ppage        = '0;
        cmd_present      = 1'b0;
        cmd_exe_writable = 1'b0;
        cmd_supervisor   = 1'b0;
        cmd_global       = 1'b0;
        cmd_count        = '0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        lookup_req   = 1'b0;
        lookup_vpage = '0;
        lookup_asid  = '0;
        clear_cmd();
        repeat (2) @(posedge clk);
        sample();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++;
        if ({strobes, cmd_done, lookup_grant, lookup_resp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000000", {strobes, cmd_done, lookup_grant, lookup_resp_valid});
        end
        checks++;
        if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        checks++;
        if ({tlb_update_ppage_idx, tlb_update_present, tlb_update_global} !== '0) begin
            errors++; $display("FAIL reset_update_fields got=%h exp=0", tlb_update_ppage_idx);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_insert();
        next_cycle();
        cmd_valid   = 1'b1;
        cmd_op      = INSERT;
        cmd_vpage   = 20'h12345;
        cmd_ppage   = 20'hABCDE;
        cmd_asid    = 16'h0042;
        cmd_present = 1'b1;
        sample();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL insert_accept_ready got=%b exp=1", cmd_ready); end
        next_cycle();
        clear_cmd();
        sample();
        checks++;
        if (strobes !== 4'b0100) begin errors++; $display("FAIL insert_strobes got=%b exp=0100", strobes); end
        checks++;
        if (tlb_request_vpage_idx !== 20'h12345 || tlb_request_asid !== 16'h0042) begin
            errors++; $display("FAIL insert_req_fields got=%h/%h exp=12345/0042", tlb_request_vpage_idx, tlb_request_asid);
        end
        checks++;
        if ({tlb_update_ppage_idx, tlb_update_present, tlb_update_exe_writable, tlb_update_supervisor, tlb_update_global}
            !== {20'hABCDE, 4'b1000}) begin
            errors++; $display("FAIL insert_upd_fields got=%h p=%b exp=abcde p=1", tlb_update_ppage_idx, tlb_update_present);
        end
        checks++;
        if (cmd_done !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL insert_t1_handshake got done=%b ready=%b exp=0/0", cmd_done, cmd_ready);
        end
        next_cycle();
        sample();
        checks++;
        if (cmd_done !== 1'b1 || strobes !== 4'b0000) begin
            errors++; $display("FAIL insert_done got done=%b strobes=%b exp=1/0000", cmd_done, strobes);
        end
        next_cycle();
        sample();
        checks++;
        if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin
            errors++; $display("FAIL insert_idle got ready=%b done=%b exp=1/0", cmd_ready, cmd_done);
        end
    endtask

    task automatic test_range_wrap();
        page_index_t exp_vpage[4];
        exp_vpage = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        next_cycle();
        cmd_valid = 1'b1;
        cmd_op    = INVAL_RANGE;
        cmd_vpage = 20'hFFFFE;
        cmd_asid  = 16'h0007;
        cmd_count = 8'd4;
        sample();
        next_cycle();
        clear_cmd();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            sample();
            checks++;
            if (strobes !== 4'b0010 || tlb_request_vpage_idx !== exp_vpage[i] || tlb_request_asid !== 16'h0007
                || cmd_done !== 1'b0) begin
                errors++;
                $display("FAIL range_issue%0d got strobes=%b vpage=%h asid=%h done=%b exp=0010/%h/0007/0",
                         i, strobes, tlb_request_vpage_idx, tlb_request_asid, cmd_done, exp_vpage[i]);
            end
        end
        next_cycle();
        sample();
        checks++;
        if (cmd_done !== 1'b1 || strobes !== 4'b0000) begin
            errors++; $display("FAIL range_done got done=%b strobes=%b exp=1/0000", cmd_done, strobes);
        end
        next_cycle();
    endtask

    task automatic test_starve();
        next_cycle();
        lookup_req   = 1'b1;
        lookup_vpage = 20'h00AAA;
        lookup_asid  = 16'h0005;
        cmd_valid    = 1'b1;
        cmd_op       = INVAL_PAGE;
        cmd_vpage    = 20'h00777;
        cmd_asid     = 16'h0009;
        sample();
        checks++;
        if (lookup_grant !== 1'b1) begin errors++; $display("FAIL starve_idle_grant got=%b exp=1", lookup_grant); end
        next_cycle();
        clear_cmd();
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            if (i > 1) next_cycle();
            sample();
            checks++;
            if (lookup_grant !== 1'b1 || strobes !== 4'b1000 || tlb_request_vpage_idx !== 20'h00AAA) begin
                errors++;
                $display("FAIL starve_lose%0d got grant=%b strobes=%b vpage=%h exp=1/1000/00aaa",
                         i, lookup_grant, strobes, tlb_request_vpage_idx);
            end
        end
        next_cycle();
        sample();
        checks++;
        if (lookup_grant !== 1'b0 || strobes !== 4'b0010 || tlb_request_vpage_idx !== 20'h00777
            || tlb_request_asid !== 16'h0009) begin
            errors++;
            $display("FAIL starve_forced got grant=%b strobes=%b vpage=%h asid=%h exp=0/0010/00777/0009",
                     lookup_grant, strobes, tlb_request_vpage_idx, tlb_request_asid);
        end
        checks++;
        if (lookup_resp_valid !== 1'b1) begin errors++; $display("FAIL starve_resp_t5 got=%b exp=1", lookup_resp_valid); end
        next_cycle();
        sample();
        checks++;
        if (cmd_done !== 1'b1 || lookup_grant !== 1'b1 || lookup_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL starve_done got done=%b grant=%b resp=%b exp=1/1/0", cmd_done, lookup_grant, lookup_resp_valid);
        end
        next_cycle();
        lookup_req = 1'b0;
    endtask

    task automatic test_range_zero();
        next_cycle();
        cmd_valid = 1'b1;
        cmd_op    = INVAL_RANGE;
        cmd_vpage = 20'h00055;
        cmd_count = 8'd0;
        sample();
        next_cycle();
        clear_cmd();
        sample();
        checks++;
        if (cmd_done !== 1'b1 || strobes !== 4'b0000) begin
            errors++; $display("FAIL range0_done got done=%b strobes=%b exp=1/0000", cmd_done, strobes);
        end
        next_cycle();
        sample();
        checks++;
        if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin
            errors++; $display("FAIL range0_idle got ready=%b done=%b exp=1/0", cmd_ready, cmd_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [COUNT_WIDTH-1:0] exp_q[$];
        logic [COUNT_WIDTH-1:0] issued;
        logic [COUNT_WIDTH-1:0] exp_issued;
        logic                   prev_grant;
        logic                   take_new;
        int                     wait_cnt;
        issued   = '0;
        wait_cnt = 0;
        take_new = 1'b1;
        prev_grant = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            next_cycle();
            lookup_req   = 1'($urandom_range(0, 1));
            lookup_vpage = page_index_t'($urandom);
            lookup_asid  = 16'($urandom);
            if (take_new) begin
                cmd_valid = 1'b1;
                cmd_op    = tlb_cmd_t'($urandom_range(0, 3));
                cmd_vpage = page_index_t'($urandom);
                cmd_asid  = 16'($urandom);
                cmd_ppage = page_index_t'($urandom);
                cmd_count = 8'($urandom_range(0, 5));
                take_new  = 1'b0;
            end
            sample();
            checks++;
            if ($countones(strobes) > 1) begin errors++; $display("FAIL b2b_onehot cyc=%0d got=%b exp<=1 set", cyc, strobes); end
            if (cyc > 0) begin
                checks++;
                if (lookup_resp_valid !== prev_grant) begin
                    errors++; $display("FAIL b2b_resp_valid cyc=%0d got=%b exp=%b", cyc, lookup_resp_valid, prev_grant);
                end
            end
            if (cmd_ready) begin
                checks++;
                if (lookup_grant !== lookup_req) begin
                    errors++; $display("FAIL b2b_idle_grant cyc=%0d got=%b exp=%b", cyc, lookup_grant, lookup_req);
                end
            end
            if (tlb_update_en || tlb_invalidate_en || tlb_invalidate_all_en) issued = issued + 1'b1;
            if (!cmd_ready && !cmd_done && !(tlb_update_en || tlb_invalidate_en || tlb_invalidate_all_en))
                wait_cnt++;
            else
                wait_cnt = 0;
            checks++;
            if (wait_cnt > STARVE_LIMIT) begin
                errors++; $display("FAIL b2b_starve cyc=%0d got=%0d exp<=%0d", cyc, wait_cnt, STARVE_LIMIT);
            end
            if (cmd_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious_done cyc=%0d got=done exp=none", cyc);
                end else begin
                    exp_issued = exp_q.pop_front();
                    if (issued !== exp_issued) begin
                        errors++; $display("FAIL b2b_issue_count cyc=%0d got=%0d exp=%0d", cyc, issued, exp_issued);
                    end
                end
                issued = '0;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back((cmd_op == INVAL_RANGE) ? cmd_count : COUNT_WIDTH'(1));
                take_new = 1'b1;
            end
            prev_grant = lookup_grant;
        end
        next_cycle();
        clear_cmd();
        lookup_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sample();
            if (tlb_update_en || tlb_invalidate_en || tlb_invalidate_all_en) issued = issued + 1'b1;
            if (cmd_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_drain_spurious got=done exp=none");
                end else begin
                    exp_issued = exp_q.pop_front();
                    if (issued !== exp_issued) begin
                        errors++; $display("FAIL b2b_drain_count got=%0d exp=%0d", issued, exp_issued);
                    end
                end
                issued = '0;
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_drain_empty got pending=%0d ready=%b exp=0/1", exp_q.size(), cmd_ready);
        end
    endtask

    task automatic test_reset_mid_sweep();
        next_cycle();
        cmd_valid = 1'b1;
        cmd_op    = INVAL_RANGE;
        cmd_vpage = 20'h00100;
        cmd_count = 8'd6;
        sample();
        next_cycle();
        clear_cmd();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            sample();
            checks++;
            if (strobes !== 4'b0010 || tlb_request_vpage_idx !== page_index_t'(20'h00100 + i)) begin
                errors++;
                $display("FAIL sweep_issue%0d got strobes=%b vpage=%h exp=0010/%h",
                         i, strobes, tlb_request_vpage_idx, 20'h00100 + i);
            end
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (strobes !== 4'b0000 || cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_reset got strobes=%b ready=%b done=%b exp=0000/1/0", strobes, cmd_ready, cmd_done);
        end
        repeat (2) next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if (cmd_done !== 1'b0 || strobes !== 4'b0000 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_after_reset%0d got done=%b strobes=%b ready=%b exp=0/0000/1",
                         i, cmd_done, strobes, cmd_ready);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_insert();
        test_range_wrap();
        test_starve();
        test_range_zero();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
